// File: rtl/refill_sched_if.sv
// Miss-capture, line-fill and wake signalling between the core, the refill scheduler and backing memory.
// The slave modport is the scheduler; the master modport is the core/memory side driving it.
interface refill_sched_if;
    logic        i_miss;
    logic [2:0]  i_miss_trd;
    logic [31:0] i_miss_addr;
    logic        d_miss;
    logic [2:0]  d_miss_trd;
    logic [31:0] d_miss_addr;
    logic [7:0]  kill;
    logic        fill_req;
    logic [31:0] fill_addr;
    logic [2:0]  fill_trd;
    logic        fill_src;
    logic        fill_ack;
    logic [7:0]  trd_wake;
    logic [7:0]  trd_pending;
    logic        timeout_err;

    modport master (
        output i_miss, i_miss_trd, i_miss_addr,
        output d_miss, d_miss_trd, d_miss_addr,
        output kill, fill_ack,
        input  fill_req, fill_addr, fill_trd, fill_src,
        input  trd_wake, trd_pending, timeout_err
    );

    modport slave (
        input  i_miss, i_miss_trd, i_miss_addr,
        input  d_miss, d_miss_trd, d_miss_addr,
        input  kill, fill_ack,
        output fill_req, fill_addr, fill_trd, fill_src,
        output trd_wake, trd_pending, timeout_err
    );
endinterface

// File: rtl/refill_sched.sv
// Round-robin line-fill scheduler for per-thread I/D misses (8 threads, one outstanding each).
// Optional REFILL_MERGE_EN: a completed fill also wakes every other pending thread on the same line.
module refill_sched #(
    parameter int LINE_BITS   = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    refill_sched_if.slave bus
);
    localparam int LW = 32 - LINE_BITS;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [7:0]    pending;
    logic [7:0]    killed;
    logic [7:0]    done_mask;
    logic [LW-1:0] line_tab [8];
    logic [7:0]    src_tab;
    logic [2:0]    rr_ptr;
    logic [2:0]    sel;
    logic [15:0]   cnt;
    logic          fill_req;
    logic [31:0]   fill_addr;
    logic          fill_src;
    logic [7:0]    trd_wake;
    logic          timeout_err;

    logic          pick_vld;
    logic [2:0]    pick;
    logic [7:0]    cap_d;
    logic [7:0]    cap_i;
    logic [7:0]    merge_mask;
    logic          kill_eff;
    logic          timeout_hit;

    assign bus.fill_req    = fill_req;
    assign bus.fill_addr   = fill_addr;
    assign bus.fill_trd    = sel;
    assign bus.fill_src    = fill_src;
    assign bus.trd_wake    = trd_wake;
    assign bus.trd_pending = pending;
    assign bus.timeout_err = timeout_err;

    // Scan downwards so the smallest offset from rr_ptr is the one that sticks.
    always_comb begin
        pick_vld = 1'b0;
        pick     = rr_ptr;
        for (int i = 7; i >= 0; i--) begin
            if (pending[rr_ptr + 3'(i)]) begin
                pick_vld = 1'b1;
                pick     = rr_ptr + 3'(i);
            end
        end
    end

    // A data miss wins over an instruction miss for the same thread; kill beats both.
    always_comb begin
        cap_d = '0;
        cap_i = '0;
        for (int t = 0; t < 8; t++) begin
            cap_d[t] = bus.d_miss && (bus.d_miss_trd == 3'(t)) && !pending[t] && !bus.kill[t];
            cap_i[t] = bus.i_miss && (bus.i_miss_trd == 3'(t)) && !pending[t] && !bus.kill[t]
                       && !cap_d[t];
        end
    end

    always_comb begin
        merge_mask = '0;
`ifdef REFILL_MERGE_EN
        for (int t = 0; t < 8; t++) begin
            if (pending[t] && !bus.kill[t] && (3'(t) != sel)
                && (line_tab[t] == fill_addr[31:LINE_BITS]))
                merge_mask[t] = 1'b1;
        end
`endif
    end

    assign kill_eff    = killed[sel] | bus.kill[sel];
    assign timeout_hit = (state == BUSY) && !bus.fill_ack && (cnt == 16'(ACK_TIMEOUT - 1));

    // NOTE: the line/src table has no reset; an entry is only ever read while its pending bit,
    // which is reset, is set.
    always_ff @(posedge clk) begin
        for (int t = 0; t < 8; t++) begin
            if (cap_d[t]) begin
                line_tab[t] <= bus.d_miss_addr[31:LINE_BITS];
                src_tab[t]  <= 1'b1;
            end else if (cap_i[t]) begin
                line_tab[t] <= bus.i_miss_addr[31:LINE_BITS];
                src_tab[t]  <= 1'b0;
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments, so a later per-bit write to pending or
    // killed in the same block overrides the whole-vector write in DONE, which is intended.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            sel         <= '0;
            cnt         <= '0;
            pending     <= '0;
            killed      <= '0;
            done_mask   <= '0;
            fill_req    <= 1'b0;
            fill_addr   <= '0;
            fill_src    <= 1'b0;
            trd_wake    <= '0;
            timeout_err <= 1'b0;
        end else begin
            trd_wake <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        sel       <= pick;
                        fill_addr <= {line_tab[pick], {LINE_BITS{1'b0}}};
                        fill_src  <= src_tab[pick];
                        fill_req  <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.fill_ack) begin
                        fill_req  <= 1'b0;
                        done_mask <= (kill_eff ? 8'h00 : (8'h01 << sel)) | merge_mask;
                        trd_wake  <= (kill_eff ? 8'h00 : (8'h01 << sel)) | merge_mask;
                        state     <= DONE;
                    end else if (timeout_hit) begin
                        fill_req    <= 1'b0;
                        timeout_err <= 1'b1;
                        killed[sel] <= 1'b0;
                        rr_ptr      <= sel + 3'd1;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    pending     <= pending & ~done_mask;
                    killed[sel] <= 1'b0;
                    rr_ptr      <= sel + 3'd1;
                    cnt         <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase

            for (int t = 0; t < 8; t++) begin
                if (bus.kill[t]) begin
                    pending[t] <= 1'b0;
                    if (((state == BUSY) && !timeout_hit && (sel == 3'(t)))
                        || ((state == IDLE) && pick_vld && (pick == 3'(t))))
                        killed[t] <= 1'b1;
                end else if (cap_d[t] || cap_i[t]) begin
                    pending[t] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_refill_sched.sv
// Self-checking bench for refill_sched: directed scenarios plus randomized misses checked against
// a transaction-level model of the thread table and round-robin service order.
module tb_refill_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    refill_sched_if bus();

    refill_sched #(.LINE_BITS(4), .ACK_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: thread table, round-robin pointer and in-flight fill.
    bit          m_pend [8];
    logic [31:0] m_addr [8];
    bit          m_src  [8];
    int          m_rr;
    bit          m_inflight;
    int          m_sel;
    logic [27:0] m_line;
    bit          m_killed;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] m_mask();
        logic [7:0] r;
        r = '0;
        for (int t = 0; t < 8; t++) r[t] = m_pend[t];
        return r;
    endfunction

    function automatic int m_pick();
        for (int i = 0; i < 8; i++)
            if (m_pend[(m_rr + i) % 8]) return (m_rr + i) % 8;
        return -1;
    endfunction

    task automatic m_reset();
        for (int t = 0; t < 8; t++) begin
            m_pend[t] = 1'b0;
            m_addr[t] = '0;
            m_src[t]  = 1'b0;
        end
        m_rr = 0;
        m_inflight = 1'b0;
        m_sel = 0;
        m_killed = 1'b0;
    endtask

    // Drive one cycle of miss/kill strobes and apply the capture rules to the model.
    task automatic drive(input bit iv, input int it, input logic [31:0] ia,
                         input bit dv, input int dt, input logic [31:0] da,
                         input logic [7:0] km);
        bus.i_miss = iv; bus.i_miss_trd = 3'(it); bus.i_miss_addr = ia;
        bus.d_miss = dv; bus.d_miss_trd = 3'(dt); bus.d_miss_addr = da;
        bus.kill   = km;
        for (int t = 0; t < 8; t++) begin
            if (km[t]) begin
                m_pend[t] = 1'b0;
                if (m_inflight && m_sel == t) m_killed = 1'b1;
            end else if (!m_pend[t]) begin
                if (dv && dt == t) begin
                    m_pend[t] = 1'b1; m_addr[t] = da; m_src[t] = 1'b1;
                end else if (iv && it == t) begin
                    m_pend[t] = 1'b1; m_addr[t] = ia; m_src[t] = 1'b0;
                end
            end
        end
        tick();
        bus.i_miss = 1'b0;
        bus.d_miss = 1'b0;
        bus.kill   = '0;
    endtask

    // Wait for the next fill request and check it against the model's round-robin choice.
    task automatic start_fill(output int waited);
        int t;
        t = m_pick();
        waited = 0;
        while (bus.fill_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        total++;
        if (bus.fill_req !== 1'b1) begin
            bad++;
            $display("FAIL fill_req_rise: fill_req=%b after %0d cycles, required 1", bus.fill_req, waited);
        end
        total++;
        if (bus.fill_trd !== 3'(t)) begin
            bad++;
            $display("FAIL fill_trd: got %0d required %0d", bus.fill_trd, t);
        end
        total++;
        if (bus.fill_addr !== {m_addr[t][31:4], 4'h0}) begin
            bad++;
            $display("FAIL fill_addr: got %h required %h", bus.fill_addr, {m_addr[t][31:4], 4'h0});
        end
        total++;
        if (bus.fill_src !== m_src[t]) begin
            bad++;
            $display("FAIL fill_src: got %b required %b", bus.fill_src, m_src[t]);
        end
        m_inflight = 1'b1;
        m_sel      = t;
        m_line     = m_addr[t][31:4];
        m_killed   = 1'b0;
    endtask

    // Hold the request ack_dly cycles, ack it, and check the wake pulse and the cleared table.
    task automatic finish_fill(input int ack_dly);
        logic [7:0] exp;
        repeat (ack_dly) tick();
        total++;
        if (bus.fill_req !== 1'b1) begin
            bad++;
            $display("FAIL fill_req_held: got %b required 1", bus.fill_req);
        end
        bus.fill_ack = 1'b1;
        tick();
        bus.fill_ack = 1'b0;
        exp = m_killed ? 8'h00 : (8'h01 << m_sel);
`ifdef REFILL_MERGE_EN
        for (int j = 0; j < 8; j++)
            if (j != m_sel && m_pend[j] && m_addr[j][31:4] == m_line) exp[j] = 1'b1;
`endif
        total++;
        if (bus.fill_req !== 1'b0) begin
            bad++;
            $display("FAIL fill_req_drop: got %b required 0", bus.fill_req);
        end
        total++;
        if (bus.trd_wake !== exp) begin
            bad++;
            $display("FAIL wake_pulse: got %h required %h", bus.trd_wake, exp);
        end
        for (int j = 0; j < 8; j++) if (exp[j]) m_pend[j] = 1'b0;
        m_rr = (m_sel + 1) % 8;
        m_inflight = 1'b0;
        m_killed = 1'b0;
        tick();
        total++;
        if (bus.trd_wake !== 8'h00) begin
            bad++;
            $display("FAIL wake_one_cycle: got %h required 00", bus.trd_wake);
        end
        total++;
        if (bus.trd_pending !== m_mask()) begin
            bad++;
            $display("FAIL pending_after_done: got %h required %h", bus.trd_pending, m_mask());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_miss = 1'b0; bus.i_miss_trd = '0; bus.i_miss_addr = '0;
        bus.d_miss = 1'b0; bus.d_miss_trd = '0; bus.d_miss_addr = '0;
        bus.kill = '0; bus.fill_ack = 1'b0;
        m_reset();
        repeat (3) tick();
        total++;
        if ({bus.fill_req, bus.fill_src, bus.timeout_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: req/src/err=%b required 000", {bus.fill_req, bus.fill_src, bus.timeout_err});
        end
        total++;
        if (bus.fill_addr !== 32'h0 || bus.fill_trd !== 3'd0) begin
            bad++;
            $display("FAIL reset_fill: addr=%h trd=%0d required 0/0", bus.fill_addr, bus.fill_trd);
        end
        total++;
        if (bus.trd_wake !== 8'h00 || bus.trd_pending !== 8'h00) begin
            bad++;
            $display("FAIL reset_masks: wake=%h pending=%h required 00/00", bus.trd_wake, bus.trd_pending);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int w;
        drive(1'b0, 0, 32'h0, 1'b1, 3, 32'h0001_0234, 8'h00);
        total++;
        if (bus.trd_pending !== 8'h08 || bus.fill_req !== 1'b0) begin
            bad++;
            $display("FAIL single_capture: pending=%h req=%b required 08/0", bus.trd_pending, bus.fill_req);
        end
        start_fill(w);
        total++;
        if (w != 1) begin
            bad++;
            $display("FAIL single_latency: fill_req after %0d cycles, required 1", w);
        end
        total++;
        if (bus.fill_addr !== 32'h0001_0230) begin
            bad++;
            $display("FAIL single_addr: got %h required 00010230", bus.fill_addr);
        end
        finish_fill(4);
    endtask

    task automatic test_rr_order();
        int w;
        int order [3];
        int want [3];
        want[0] = 6; want[1] = 0; want[2] = 5;
        drive(1'b0, 0, 32'h0, 1'b1, 5, 32'h0000_5500, 8'h00);
        start_fill(w);
        drive(1'b1, 0, 32'h0000_0100, 1'b1, 6, 32'h0000_6600, 8'h00);
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 8'h20);
        drive(1'b0, 0, 32'h0, 1'b1, 5, 32'h0000_5570, 8'h00);
        finish_fill(1);
        for (int n = 0; n < 3; n++) begin
            start_fill(w);
            order[n] = int'(bus.fill_trd);
            finish_fill(n);
        end
        for (int n = 0; n < 3; n++) begin
            total++;
            if (order[n] != want[n]) begin
                bad++;
                $display("FAIL rr_order[%0d]: got thread %0d required %0d", n, order[n], want[n]);
            end
        end
    endtask

    task automatic test_same_thread();
        int w;
        int fills;
        drive(1'b1, 2, 32'h0000_2200, 1'b1, 2, 32'h0002_2240, 8'h00);
        start_fill(w);
        drive(1'b0, 0, 32'h0, 1'b1, 2, 32'h0009_9990, 8'h00);
        finish_fill(1);
        bus.fill_ack = 1'b1;
        tick();
        bus.fill_ack = 1'b0;
        fills = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.fill_req === 1'b1 || bus.trd_wake !== 8'h00) fills++;
            tick();
        end
        total++;
        if (fills != 0) begin
            bad++;
            $display("FAIL same_thread_extra: %0d cycles of activity, required 0", fills);
        end
    endtask

    task automatic test_kill();
        int w;
        drive(1'b1, 1, 32'h0000_1110, 1'b0, 0, 32'h0, 8'h00);
        start_fill(w);
        drive(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 8'h02);
        total++;
        if (bus.trd_pending[1] !== 1'b0 || bus.fill_req !== 1'b1) begin
            bad++;
            $display("FAIL kill_inflight: pending1=%b req=%b required 0/1", bus.trd_pending[1], bus.fill_req);
        end
        finish_fill(2);
    endtask

    task automatic test_timeout();
        int w;
        int high;
        drive(1'b0, 0, 32'h0, 1'b1, 7, 32'h0007_7000, 8'h00);
        start_fill(w);
        high = 1;
        while (bus.fill_req === 1'b1 && high < 30) begin
            tick();
            if (bus.fill_req === 1'b1) high++;
        end
        total++;
        if (high != 8) begin
            bad++;
            $display("FAIL timeout_len: fill_req high %0d cycles, required 8", high);
        end
        total++;
        if (bus.timeout_err !== 1'b1 || bus.trd_pending !== 8'h80) begin
            bad++;
            $display("FAIL timeout_state: err=%b pending=%h required 1/80", bus.timeout_err, bus.trd_pending);
        end
        m_rr = (m_sel + 1) % 8;
        m_inflight = 1'b0;
        start_fill(w);
        finish_fill(2);
        total++;
        if (bus.timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got %b required 1", bus.timeout_err);
        end
    endtask

    task automatic test_merge();
        int w;
        int fills;
        int want;
`ifdef REFILL_MERGE_EN
        want = 1;
`else
        want = 2;
`endif
        drive(1'b1, 0, 32'h0000_4000, 1'b1, 4, 32'h0000_4008, 8'h00);
        fills = 0;
        while (m_pick() >= 0 && fills < 4) begin
            start_fill(w);
            finish_fill(1);
            fills++;
        end
        total++;
        if (fills != want) begin
            bad++;
            $display("FAIL merge_fills: got %0d fills required %0d", fills, want);
        end
    endtask

    task automatic test_random();
        int w;
        int guard;
        for (int it = 0; it < 40; it++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
            guard = 0;
            while (m_pick() >= 0 && guard < 10) begin
                start_fill(w);
                if ($urandom_range(0, 1) == 1)
                    drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom(),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom(), 8'h00);
                finish_fill(int'($urandom_range(0, 4)));
                guard++;
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int w;
        drive(1'b0, 0, 32'h0, 1'b1, 4, 32'h0004_4440, 8'h00);
        start_fill(w);
        rst_n = 1'b0;
        tick();
        total++;
        if (bus.fill_req !== 1'b0 || bus.trd_pending !== 8'h00 || bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_fill: req=%b pending=%h err=%b required 0/00/0",
                     bus.fill_req, bus.trd_pending, bus.timeout_err);
        end
        rst_n = 1'b1;
        m_reset();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_rr_order();
        test_same_thread();
        test_kill();
        test_merge();
        test_random();
        test_timeout();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
